// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the hazard controller and its counters.
package cpu_pkg;

    // Hazard controller FSM states
    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } hazard_state_e;

    // Bit of the EX-stage memory-read control field that marks a load
    localparam int LOAD_BIT = 3;

    // Width of the performance counters
    localparam int CNT_W = 16;

    // All hold/flush/bubble controls driven by the hazard unit
    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic id_ex_hold;
        logic ex_mem_hold;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } hazard_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter
    import cpu_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps every register reading pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves memory stalls, taken branches and
// load-use hazards into PC/pipeline hold, flush and bubble controls.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_reg_read_addr1,
    input  logic [4:0]       id_reg_read_addr2,
    input  logic [4:0]       ex_reg_write_addr,
    input  logic [3:0]       ex_data_mem_read,
    input  logic             branch_taken,
    input  logic             data_mem_busy,
    input  logic             instr_mem_busy,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    hazard_state_e state, state_next;
    hazard_ctrl_t  ctrl;
    logic          discard_pending, discard_next;
    logic          load_use, discard_done, branch_flush;

    // Only the load flag of the memory-read field matters here
    logic unused_mem_read;
    assign unused_mem_read = ^ex_data_mem_read;

    // Load in EX whose (non-x0) destination is a source of the ID instruction
    assign load_use = ex_data_mem_read[LOAD_BIT]
                   && (ex_reg_write_addr != 5'd0)
                   && ((ex_reg_write_addr == id_reg_read_addr1)
                    || (ex_reg_write_addr == id_reg_read_addr2));

    // Next state, priority resolution of controls and discard-flag update
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_next   = state;
        ctrl         = '0;
        discard_next = discard_pending;
        discard_done = 1'b0;
        branch_flush = 1'b0;

        case (state)
            RUN:       if (data_mem_busy)  state_next = DMEM_WAIT;
            DMEM_WAIT: if (!data_mem_busy) state_next = RUN;
            default:   state_next = RUN;
        endcase

        if (reset) begin
            state_next   = RUN;
            discard_next = 1'b0;
        end else if (data_mem_busy) begin
            ctrl.pc_hold       = 1'b1;
            ctrl.if_id_hold    = 1'b1;
            ctrl.id_ex_hold    = 1'b1;
            ctrl.ex_mem_hold   = 1'b1;
            ctrl.mem_wb_bubble = 1'b1;
        end else if (discard_pending && !instr_mem_busy) begin
            // Fetch that was in flight at the branch has landed: drop it
            discard_done     = 1'b1;
            discard_next     = 1'b0;
            ctrl.pc_hold     = 1'b1;
            ctrl.if_id_flush = 1'b1;
        end else if (branch_taken) begin
            branch_flush     = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            // A wrong-path fetch still outstanding must be discarded on return
            if (instr_mem_busy) discard_next = 1'b1;
        end else if (load_use) begin
            ctrl.pc_hold     = 1'b1;
            ctrl.if_id_hold  = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (instr_mem_busy) begin
            ctrl.pc_hold     = 1'b1;
            ctrl.if_id_flush = 1'b1;
        end
    end

    // FSM state and discard flag registers
    always_ff @(posedge clk) begin
        state           <= state_next;
        discard_pending <= discard_next;
    end

    assign pc_hold       = ctrl.pc_hold;
    assign if_id_hold    = ctrl.if_id_hold;
    assign id_ex_hold    = ctrl.id_ex_hold;
    assign ex_mem_hold   = ctrl.ex_mem_hold;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl.pc_hold),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (branch_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, ex_rd;
    logic [3:0]  mem_read;
    logic        branch, dbusy, ibusy;
    logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [15:0] stall_count, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected control vectors: {pc, if_id, id_ex, ex_mem hold, if_id, id_ex flush, bubble}
    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] FREEZE = 7'b1111001;
    localparam logic [6:0] BRANCH = 7'b0000110;
    localparam logic [6:0] LDUSE  = 7'b1100010;
    localparam logic [6:0] IFLUSH = 7'b1000100;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .id_reg_read_addr1 (rs1),
        .id_reg_read_addr2 (rs2),
        .ex_reg_write_addr (ex_rd),
        .ex_data_mem_read  (mem_read),
        .branch_taken      (branch),
        .data_mem_busy     (dbusy),
        .instr_mem_busy    (ibusy),
        .pc_hold           (pc_hold),
        .if_id_hold        (if_id_hold),
        .id_ex_hold        (id_ex_hold),
        .ex_mem_hold       (ex_mem_hold),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .mem_wb_bubble     (mem_wb_bubble),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                         input logic [3:0] mr, input logic br, input logic db, input logic ib);
        rs1 = a1; rs2 = a2; ex_rd = rd; mem_read = mr;
        branch = br; dbusy = db; ibusy = ib;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare the combinational controls mid-cycle
    task automatic check_ctrl(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        @(negedge clk);
        obs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_wb_bubble};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: controls observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare a counter value just after an edge
    task automatic check_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with hazards present: controls must stay quiet
        reset = 1'b1;
        drive(5'd5, 5'd0, 5'd5, 4'b1000, 1'b1, 1'b1, 1'b1);
        check_ctrl("reset_ctrl_zero", NONE);
        cyc(); cyc();
        reset = 1'b0;
        idle();
        check_cnt("reset_stall_cnt", stall_count, 16'd0);
        check_cnt("reset_flush_cnt", flush_count, 16'd0);
        check_ctrl("idle", NONE);
        cyc();

        // Load to x5, ID reads x5 on rs1 then on rs2
        drive(5'd5, 5'd7, 5'd5, 4'b1000, 1'b0, 1'b0, 1'b0);
        check_ctrl("load_use_rs1", LDUSE);
        cyc();
        check_cnt("load_use_stall_1", stall_count, 16'd1);
        drive(5'd3, 5'd5, 5'd5, 4'b1010, 1'b0, 1'b0, 1'b0);
        check_ctrl("load_use_rs2", LDUSE);
        cyc();
        check_cnt("load_use_stall_2", stall_count, 16'd2);

        // Load to x0 and non-load with matching address: no hazard
        drive(5'd0, 5'd0, 5'd0, 4'b1000, 1'b0, 1'b0, 1'b0);
        check_ctrl("load_x0", NONE);
        cyc();
        drive(5'd9, 5'd1, 5'd9, 4'b0111, 1'b0, 1'b0, 1'b0);
        check_ctrl("non_load_match", NONE);
        cyc();
        check_cnt("no_stall_cnt", stall_count, 16'd2);

        // Branch wins over load-use
        drive(5'd5, 5'd0, 5'd5, 4'b1000, 1'b1, 1'b0, 1'b0);
        check_ctrl("branch_over_load_use", BRANCH);
        cyc();
        check_cnt("branch_flush_cnt", flush_count, 16'd1);
        check_cnt("branch_stall_cnt", stall_count, 16'd2);

        // Data memory busy 3 cycles with branch held, then one flush
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 5'd0, 4'd0, 1'b1, 1'b1, 1'b0);
            check_ctrl("dmem_freeze", FREEZE);
            cyc();
        end
        check_cnt("dmem_stall_cnt", stall_count, 16'd5);
        check_cnt("dmem_flush_cnt_hold", flush_count, 16'd1);
        drive(5'd0, 5'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_ctrl("dmem_exit_branch", BRANCH);
        cyc();
        check_cnt("dmem_exit_flush_cnt", flush_count, 16'd2);
        check_cnt("dmem_exit_stall_cnt", stall_count, 16'd5);

        // Branch while fetch outstanding; fetch returns two cycles later
        drive(5'd0, 5'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b1);
        check_ctrl("branch_imem_busy", BRANCH);
        cyc();
        check_cnt("discard_flush_cnt", flush_count, 16'd3);
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);
            check_ctrl("imem_wait", IFLUSH);
            cyc();
        end
        idle();
        check_ctrl("discard_done", IFLUSH);
        cyc();
        check_cnt("discard_stall_cnt", stall_count, 16'd8);
        check_ctrl("discard_cleared", NONE);
        cyc();

        // Instruction memory busy alone
        drive(5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check_ctrl("imem_busy_only", IFLUSH);
        cyc();
        check_cnt("imem_stall_cnt", stall_count, 16'd9);

        // Reset in the middle of a data-memory freeze
        drive(5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_ctrl("pre_reset_freeze", FREEZE);
        cyc();
        reset = 1'b1;
        check_ctrl("reset_mid_freeze", NONE);
        cyc();
        reset = 1'b0;
        idle();
        check_cnt("mid_reset_stall_cnt", stall_count, 16'd0);
        check_cnt("mid_reset_flush_cnt", flush_count, 16'd0);
        check_ctrl("after_mid_reset", NONE);
        cyc();

        // Drive the stall counter to 16'hFFFE, then three more stalls
        drive(5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        repeat (65534) cyc();
        check_cnt("stall_cnt_fffe", stall_count, 16'hFFFE);
        repeat (3) cyc();
        check_cnt("stall_cnt_saturate", stall_count, 16'hFFFF);
        idle();
        check_ctrl("post_saturate_idle", NONE);
        cyc();
        check_cnt("stall_cnt_stays", stall_count, 16'hFFFF);
        check_cnt("flush_cnt_untouched", flush_count, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
